// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and constants for the counter scheduler
package counter_sched_pkg;

  localparam int unsigned SYNC_LAT_DEF = 2;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LWAIT  = 3'd2,
    ST_RUN    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5
  } state_e;

  // Number of count steps from start to target, modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] count_distance(
    input logic [CNT_W-1:0] start,
    input logic [CNT_W-1:0] target,
    input logic             dir_up
  );
    return dir_up ? (target - start) : (start - target);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with explicit advance
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic prio_q;
  logic prio_d;

  // Priority flips to the other requester each time an operation completes.
  always_comb begin
    prio_d = prio_q;
    if (advance_i) begin
      prio_d = ~prio_q;
    end
  end

  // Priority pointer; requester 0 is favoured out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Favoured requester wins if asking, otherwise the other one.
  always_comb begin
    grant_o = 2'b00;
    if (req_i[prio_q]) begin
      grant_o[prio_q] = 1'b1;
    end else if (req_i[~prio_q]) begin
      grant_o[~prio_q] = 1'b1;
    end
  end

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - schedules two requesters onto one synchronized up/down counter
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned SYNC_LAT = SYNC_LAT_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [1:0]            req_i,
  input  logic [1:0][CNT_W-1:0] req_start_i,
  input  logic [1:0][CNT_W-1:0] req_target_i,
  input  logic [1:0]            req_dir_i,
  output logic [1:0]            grant_o,
  output logic [1:0]            done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  cnt_load_o,
  output logic                  cnt_pause_o,
  output logic                  cnt_dir_o,
  output logic [CNT_W-1:0]      cnt_parallel_in_o,
  input  logic [CNT_W-1:0]      cnt_value_i
);

  // Timer reload for the synchronizer wait states (SYNC_LAT+1 cycles each).
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SYNC_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       grant_q;
  logic [CNT_W-1:0] start_q, target_q, dist_q;
  logic             dir_q;
  logic [1:0]       arb_gnt;
  logic             arb_sel;
  logic             advance;

  rr_arbiter2 u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .advance_i (advance),
    .grant_o   (arb_gnt)
  );

  assign arb_sel = arb_gnt[1];

  // State and shared wait/run down-counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Sequencing: one timer counts down each timed state to zero, then moves on.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_LWAIT;
        timer_d = WAIT_LAST;
      end
      ST_LWAIT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (dist_q == '0) begin
          state_d = ST_SETTLE;
          timer_d = WAIT_LAST;
        end else begin
          state_d = ST_RUN;
          timer_d = dist_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = ST_SETTLE;
          timer_d = WAIT_LAST;
        end
      end
      ST_SETTLE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner and its operation parameters are captured once at grant and held to CHECK.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q  <= 2'b00;
      start_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      dist_q   <= '0;
    end else if (state_q == ST_IDLE && (|req_i)) begin
      grant_q  <= arb_gnt;
      start_q  <= req_start_i[arb_sel];
      target_q <= req_target_i[arb_sel];
      dir_q    <= req_dir_i[arb_sel];
      dist_q   <= count_distance(req_start_i[arb_sel], req_target_i[arb_sel],
                                 req_dir_i[arb_sel]);
    end else if (state_q == ST_CHECK) begin
      grant_q  <= 2'b00;
    end
  end

  // Outputs decoded from state or taken from the captured registers only.
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    cnt_load_o  = (state_q == ST_LOAD);
    cnt_pause_o = (state_q != ST_RUN);
    advance     = (state_q == ST_CHECK);
    done_o      = (state_q == ST_CHECK) ? grant_q : 2'b00;
    err_o       = (state_q == ST_CHECK) && (cnt_value_i != target_q);
  end

  assign grant_o           = grant_q;
  assign cnt_dir_o         = dir_q;
  assign cnt_parallel_in_o = start_q;

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - randomized self-checking bench for counter_sched
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int SL = 2;
  localparam int D  = SL + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_i;
  logic [1:0][7:0] req_start_i;
  logic [1:0][7:0] req_target_i;
  logic [1:0]      req_dir_i;
  logic [1:0]      grant_o;
  logic [1:0]      done_o;
  logic            err_o;
  logic            busy_o;
  logic            cnt_load_o;
  logic            cnt_pause_o;
  logic            cnt_dir_o;
  logic [7:0]      cnt_parallel_in_o;
  logic [7:0]      cnt_value;

  int checks = 0;
  int errors = 0;
  int prio   = 0;
  bit stall_req = 1'b0;

  logic [7:0] st [2];
  logic [7:0] tg [2];
  logic       dr [2];

  always #5 clk = ~clk;

  counter_sched #(.SYNC_LAT(SL)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .req_i             (req_i),
    .req_start_i       (req_start_i),
    .req_target_i      (req_target_i),
    .req_dir_i         (req_dir_i),
    .grant_o           (grant_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .busy_o            (busy_o),
    .cnt_load_o        (cnt_load_o),
    .cnt_pause_o       (cnt_pause_o),
    .cnt_dir_o         (cnt_dir_o),
    .cnt_parallel_in_o (cnt_parallel_in_o),
    .cnt_value_i       (cnt_value)
  );

  // Counter whose controls pass through a D-deep synchronizer; may drop its first step.
  logic [D-1:0] pl, pp, pd;
  logic [7:0]   ppin [D];
  int           run_idx;

  always @(posedge clk) begin
    if (reset) begin
      pl <= '0; pp <= '1; pd <= '0; cnt_value <= 8'd0; run_idx <= 0;
      for (int i = 0; i < D; i++) ppin[i] <= 8'd0;
    end else begin
      if (pl[D-1]) begin
        cnt_value <= ppin[D-1];
        run_idx   <= 0;
      end else if (!pp[D-1]) begin
        run_idx <= run_idx + 1;
        if (!(stall_req && run_idx == 0))
          cnt_value <= pd[D-1] ? cnt_value + 8'd1 : cnt_value - 8'd1;
      end
      pl <= {pl[D-2:0], cnt_load_o};
      pp <= {pp[D-2:0], cnt_pause_o};
      pd <= {pd[D-2:0], cnt_dir_o};
      ppin[0] <= cnt_parallel_in_o;
      for (int i = 1; i < D; i++) ppin[i] <= ppin[i-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
    chk({tag, "_err"},   32'(err_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_load"},  32'(cnt_load_o), 0);
    chk({tag, "_pause"}, 32'(cnt_pause_o), 1);
    chk({tag, "_dir"},   32'(cnt_dir_o), 0);
    chk({tag, "_pin"},   32'(cnt_parallel_in_o), 0);
  endtask

  // One full operation; caller guarantees the DUT is idle at the current negedge.
  task automatic do_op(input logic [1:0] reqs, input bit keep, input bit drop, input bit stall);
    int o, lat, nload, nrun;
    logic [7:0] s, t, d, fin;
    logic dir;
    bit early, wrong;
    o   = reqs[prio] ? prio : 1 - prio;
    s   = st[o]; t = tg[o]; dir = dr[o];
    d   = dir ? 8'(t - s) : 8'(s - t);
    lat = int'(d) + 2 * SL + 3;
    stall_req = stall && (d != 8'd0);
    fin = stall_req ? (dir ? 8'(t - 8'd1) : 8'(t + 8'd1)) : t;
    for (int i = 0; i < 2; i++) begin
      req_start_i[i] = st[i]; req_target_i[i] = tg[i]; req_dir_i[i] = dr[i];
    end
    req_i = reqs;
    tick();
    chk("grant_owner", 32'(grant_o), 32'(1 << o));
    chk("busy_on", 32'(busy_o), 1);
    if (drop) req_i = 2'b00;
    req_start_i  = 16'($urandom);
    req_target_i = 16'($urandom);
    req_dir_i    = 2'($urandom);
    nload = 0; nrun = 0; early = 0; wrong = 0;
    for (int k = 0; k < lat; k++) begin
      if (cnt_load_o) nload++;
      if (!cnt_pause_o) nrun++;
      if (done_o != 2'b00) early = 1;
      if (grant_o != 2'(1 << o) || cnt_dir_o != dir || cnt_parallel_in_o != s) wrong = 1;
      tick();
    end
    chk("load_cycles", 32'(nload), 1);
    chk("run_cycles", 32'(nrun), 32'(d));
    chk("early_done", 32'(early), 0);
    chk("held_ctrl", 32'(wrong), 0);
    chk("done_owner", 32'(done_o), 32'(1 << o));
    chk("err", 32'(err_o), 32'(stall_req));
    chk("final_value", 32'(cnt_value), 32'(fin));
    stall_req = 1'b0;
    if (!keep) req_i = 2'b00;
    tick();
    chk("idle_grant", 32'(grant_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    prio = 1 - prio;
  endtask

  initial begin
    reset = 1'b1; req_i = 2'b00;
    req_start_i = '0; req_target_i = '0; req_dir_i = '0;
    for (int i = 0; i < 2; i++) begin st[i] = 8'd0; tg[i] = 8'd0; dr[i] = 1'b0; end
    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    st[0] = 8'd10; tg[0] = 8'd15; dr[0] = 1'b1;
    do_op(2'b01, 1'b0, 1'b0, 1'b0);
    st[1] = 8'd3; tg[1] = 8'd254; dr[1] = 1'b0;
    do_op(2'b10, 1'b0, 1'b0, 1'b0);
    st[0] = 8'd77; tg[0] = 8'd77; dr[0] = 1'b1;
    do_op(2'b01, 1'b0, 1'b0, 1'b0);
    st[1] = 8'd250; tg[1] = 8'd4; dr[1] = 1'b1;
    do_op(2'b10, 1'b0, 1'b1, 1'b0);
    st[0] = 8'd10; tg[0] = 8'd15; dr[0] = 1'b1;
    do_op(2'b01, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = 8'($urandom); tg[i] = 8'(st[i] + 8'($urandom_range(0, 20))); dr[i] = 1'b1;
      end
      do_op(2'b11, 1'b1, 1'b0, 1'b0);
    end
    req_i = 2'b00;
    tick();

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = 8'($urandom); tg[i] = 8'($urandom); dr[i] = 1'($urandom);
      end
      do_op(2'($urandom_range(1, 3)), 1'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    if (prio == 0) begin
      st[0] = 8'd1; tg[0] = 8'd2; dr[0] = 1'b1;
      do_op(2'b01, 1'b0, 1'b0, 1'b0);
    end
    st[1] = 8'd0; tg[1] = 8'd100; dr[1] = 1'b1;
    req_start_i[1] = st[1]; req_target_i[1] = tg[1]; req_dir_i[1] = dr[1];
    req_i = 2'b10;
    tick();
    chk("rr_grant1", 32'(grant_o), 2);
    for (int k = 0; k < 8; k++) tick();
    chk("in_run", 32'(cnt_pause_o), 0);
    req_i = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    prio = 0;
    begin
      bit saw_done;
      saw_done = 0;
      for (int k = 0; k < 120; k++) begin
        if (done_o != 2'b00 || grant_o != 2'b00) saw_done = 1;
        tick();
      end
      chk("no_done_after_rst", 32'(saw_done), 0);
    end
    st[0] = 8'd5; tg[0] = 8'd2; dr[0] = 1'b0;
    st[1] = 8'd9; tg[1] = 8'd9; dr[1] = 1'b1;
    do_op(2'b11, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
